// File: rtl/cv1k_serial_eeprom.sv
// ----------------------------------------------------------------------------
// cv1k_serial_eeprom
//   FPGA-side model of a 93C46-style x16 serial EEPROM. It sits behind the
//   CS4 EEPROM window (A23:A22=11) and is driven by the bit-banged lines
//   that the CPLD produces. The CPLD samples eeprom_do into data[0] on
//   EEPROM reads.
//
//   Ports
//     clock          system clock, all logic on the rising edge
//     reset          asynchronous, active-low
//     eeprom_ce      chip enable from the CPLD, active high
//     eeprom_clock   serial clock from the CPLD (asynchronous, oversampled)
//     eeprom_di      serial data in, MSB first
//     eeprom_do      serial data out, or ready/busy status
//     busy           high while a program cycle is in progress
//     write_protect  (only with SEEPROM_WP_PIN_EN) active-high write protect
//
//   Optional feature macro: SEEPROM_WP_PIN_EN adds the write_protect pin.
//   When the macro is undefined, write protection comes from ewen alone.
//
//   Timing: the pin sclk rise reaches eeprom_do after SYNC_STAGES+1 clocks.
//   The host must hold each sclk phase for at least SYNC_STAGES+2 clocks.
// ----------------------------------------------------------------------------
module cv1k_serial_eeprom #(
  parameter int ADDR_BITS   = 6,
  parameter int DATA_BITS   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int PROG_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic eeprom_ce,
  input  logic eeprom_clock,
  input  logic eeprom_di,
`ifdef SEEPROM_WP_PIN_EN
  input  logic write_protect,
`endif
  output logic eeprom_do,
  output logic busy
);

  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int CNT_MAX = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
  localparam int CNT_W  = $clog2(CNT_MAX + 1);
  localparam int PCNT_W = $clog2(PROG_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, START, OPCODE, ADDR, READ_OUT, WRITE_DATA, WAIT_CE_LOW, PROGRAM
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_WRITE, CMD_ERASE, CMD_ERAL, CMD_WRAL
  } cmd_t;

  // Input synchronisers
  logic [SYNC_STAGES-1:0] ce_sync, sclk_sync, di_sync;
  logic                   sclk_last;
  logic                   ce_s, sclk_s, di_s, rise;

`ifdef SEEPROM_WP_PIN_EN
  logic [SYNC_STAGES-1:0] wp_sync;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wp_sync <= '0;
    else        wp_sync <= {wp_sync[SYNC_STAGES-2:0], write_protect};
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ce_sync   <= '0;
      sclk_sync <= '0;
      di_sync   <= '0;
      sclk_last <= 1'b0;
    end else begin
      ce_sync   <= {ce_sync[SYNC_STAGES-2:0], eeprom_ce};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], eeprom_clock};
      di_sync   <= {di_sync[SYNC_STAGES-2:0], eeprom_di};
      sclk_last <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign ce_s   = ce_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign di_s   = di_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_last;

  // Protocol state
  state_t                 state_q, state_d;
  cmd_t                   cmd_q, cmd_d;
  logic [1:0]             op_q, op_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PCNT_W-1:0]      prog_cnt_q, prog_cnt_d;
  logic                   ewen_q, ewen_d;
  logic                   do_q, do_d;

  // The array holds the complement of each word, so a zero power-up state
  // of the storage reads back as the erased value of all 1s.
  logic [DATA_BITS-1:0]   mem_q [DEPTH];
  logic                   mem_we, mem_all;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic [DATA_BITS-1:0]   mem_wdata;

  logic [ADDR_BITS-1:0]   full_addr, addr_inc;
  logic                   prog_ok;

  assign full_addr = {addr_q[ADDR_BITS-2:0], di_s};
  assign addr_inc  = addr_q + ADDR_BITS'(1);

`ifdef SEEPROM_WP_PIN_EN
  assign prog_ok = (cmd_q != CMD_NONE) && ewen_q && !wp_sync[SYNC_STAGES-1];
`else
  assign prog_ok = (cmd_q != CMD_NONE) && ewen_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cmd_q      <= CMD_NONE;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      prog_cnt_q <= '0;
      ewen_q     <= 1'b0;
      do_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      prog_cnt_q <= prog_cnt_d;
      ewen_q     <= ewen_d;
      do_q       <= do_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    prog_cnt_d = prog_cnt_q;
    ewen_d     = ewen_q;
    do_d       = do_q;
    mem_we     = 1'b0;
    mem_all    = 1'b0;
    mem_waddr  = addr_q;
    mem_wdata  = data_q;

    if (state_q == PROGRAM) begin
      // Busy status is only driven while the host has the chip selected.
      do_d = ~ce_s;
      if (prog_cnt_q != PCNT_W'(PROG_CYCLES - 1)) begin
        prog_cnt_d = prog_cnt_q + PCNT_W'(1);
      end else begin
        case (cmd_q)
          CMD_WRAL: begin
            // One word per clock; addr_q was cleared on entry.
            mem_we = 1'b1;
            addr_d = addr_inc;
            if (addr_q == {ADDR_BITS{1'b1}}) begin
              state_d = IDLE;
              cmd_d   = CMD_NONE;
              do_d    = 1'b1;
            end
          end
          CMD_ERAL: begin
            mem_all   = 1'b1;
            mem_wdata = '1;
            state_d   = IDLE;
            cmd_d     = CMD_NONE;
            do_d      = 1'b1;
          end
          CMD_ERASE: begin
            mem_we    = 1'b1;
            mem_wdata = '1;
            state_d   = IDLE;
            cmd_d     = CMD_NONE;
            do_d      = 1'b1;
          end
          default: begin
            mem_we  = 1'b1;
            state_d = IDLE;
            cmd_d   = CMD_NONE;
            do_d    = 1'b1;
          end
        endcase
      end
    end else if (!ce_s) begin
      // Deselect wins over a coincident sclk edge. Only a completed
      // write-type command with writes enabled goes on to program.
      do_d = 1'b1;
      if (state_q == WAIT_CE_LOW && prog_ok) begin
        state_d    = PROGRAM;
        prog_cnt_d = '0;
        if (cmd_q == CMD_WRAL) addr_d = '0;
      end else begin
        state_d = IDLE;
        cmd_d   = CMD_NONE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = START;
          cmd_d   = CMD_NONE;
          do_d    = 1'b1;
        end
        START: begin
          do_d = 1'b1;
          if (rise && di_s) begin
            state_d = OPCODE;
            cnt_d   = '0;
          end
        end
        OPCODE: begin
          if (rise) begin
            op_d = {op_q[0], di_s};
            if (cnt_q == CNT_W'(1)) begin
              state_d = ADDR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ADDR: begin
          if (rise) begin
            addr_d = full_addr;
            if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
              cnt_d = '0;
              case (op_q)
                2'b10: begin
                  state_d = READ_OUT;
                  do_d    = 1'b0;
                  data_d  = ~mem_q[full_addr];
                  cnt_d   = CNT_W'(DATA_BITS - 1);
                end
                2'b01: begin
                  cmd_d   = CMD_WRITE;
                  state_d = WRITE_DATA;
                end
                2'b11: begin
                  cmd_d   = CMD_ERASE;
                  state_d = WAIT_CE_LOW;
                end
                default: begin
                  state_d = WAIT_CE_LOW;
                  case (full_addr[ADDR_BITS-1 -: 2])
                    2'b11: ewen_d = 1'b1;
                    2'b00: ewen_d = 1'b0;
                    2'b10: cmd_d  = CMD_ERAL;
                    default: begin
                      cmd_d   = CMD_WRAL;
                      state_d = WRITE_DATA;
                    end
                  endcase
                end
              endcase
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        READ_OUT: begin
          // data_q doubles as the output shift register during reads.
          if (rise) begin
            do_d   = data_q[DATA_BITS-1];
            data_d = {data_q[DATA_BITS-2:0], 1'b0};
            if (cnt_q == '0) begin
              addr_d = addr_inc;
              data_d = ~mem_q[addr_inc];
              cnt_d  = CNT_W'(DATA_BITS - 1);
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        WRITE_DATA: begin
          if (rise) begin
            data_d = {data_q[DATA_BITS-2:0], di_s};
            if (cnt_q == CNT_W'(DATA_BITS - 1)) state_d = WAIT_CE_LOW;
            else                                cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        WAIT_CE_LOW: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Array storage, deliberately outside reset so an interrupted program
  // cycle leaves the old contents in place.
  always_ff @(posedge clock) begin
    if (mem_all) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= ~mem_wdata;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= ~mem_wdata;
    end
  end

  assign eeprom_do = do_q;
  assign busy      = (state_q == PROGRAM);

endmodule

// File: tb/tb_cv1k_serial_eeprom.sv
module tb_cv1k_serial_eeprom;

  localparam int AB    = 6;
  localparam int DB    = 16;
  localparam int SS    = 2;
  localparam int PC    = 64;
  localparam int DEPTH = 1 << AB;
  localparam int HALF  = SS + 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ce    = 1'b0;
  logic sclk  = 1'b0;
  logic di    = 1'b0;
  logic eeprom_do;
  logic busy;
`ifdef SEEPROM_WP_PIN_EN
  logic wp = 1'b0;
`endif

  cv1k_serial_eeprom #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .SYNC_STAGES(SS), .PROG_CYCLES(PC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .eeprom_ce(ce),
    .eeprom_clock(sclk),
    .eeprom_di(di),
`ifdef SEEPROM_WP_PIN_EN
    .write_protect(wp),
`endif
    .eeprom_do(eeprom_do),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: word contents and the write-enable latch.
  logic [DB-1:0] model_mem [DEPTH];
  bit            model_ewen = 1'b0;
  logic [DB-1:0] rd_buf [4];

  bit busy_allowed = 1'b0;
  bit idle_exp     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle checks: busy never rises outside an expected program cycle,
  // and a deselected chip always shows eeprom_do high.
  always @(negedge clock) begin
    if (reset) begin
      if (!busy_allowed) chk("busy_unexpected", {31'd0, busy}, 32'd0);
      if (idle_exp)      chk("do_idle", {31'd0, eeprom_do}, 32'd1);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b, output logic d);
    di = b;
    sclk = 1'b0;
    wait_clk(HALF);
    sclk = 1'b1;
    wait_clk(HALF);
    d = eeprom_do;
  endtask

  task automatic begin_cmd();
    idle_exp = 1'b0;
    ce = 1'b1;
    wait_clk(HALF);
    chk("start_ready", {31'd0, eeprom_do}, 32'd1);
  endtask

  task automatic send_hdr(input logic [1:0] op, input logic [AB-1:0] a, output logic last_do);
    logic d;
    send_bit(1'b1, d);
    send_bit(op[1], d);
    send_bit(op[0], d);
    for (int i = AB - 1; i >= 0; i--) send_bit(a[i], d);
    last_do = d;
  endtask

  task automatic drop_ce();
    sclk = 1'b0;
    wait_clk(HALF);
    ce = 1'b0;
  endtask

  task automatic settle_none();
    wait_clk(HALF);
    idle_exp = 1'b1;
  endtask

  task automatic settle_prog(input bit expect_prog, input int min_len, input int max_len,
                             input string name);
    int hi;
    bit seen;
    bit done;
    int bound;
    hi = 0; seen = 0; done = 0;
    bound = expect_prog ? (PC + DEPTH + 40) : 40;
    if (expect_prog) busy_allowed = 1'b1;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clock);
      if (busy) begin
        hi++;
        seen = 1'b1;
      end else if (seen) begin
        done = 1'b1;
      end
    end
    if (expect_prog) begin
      chk({name, "_busy_done"}, {31'd0, done}, 32'd1);
      if (min_len == max_len) chk({name, "_busy_len"}, hi, min_len);
      else chk({name, "_busy_len_range"}, {31'd0, (hi >= min_len && hi <= max_len)}, 32'd1);
    end else begin
      chk({name, "_no_busy"}, hi, 0);
    end
    busy_allowed = 1'b0;
    wait_clk(2);
    idle_exp = 1'b1;
  endtask

  task automatic cmd_ewen();
    logic d;
    begin_cmd();
    send_hdr(2'b00, 6'h30, d);
    drop_ce();
    settle_none();
    model_ewen = 1'b1;
  endtask

  task automatic cmd_ewds();
    logic d;
    begin_cmd();
    send_hdr(2'b00, 6'h00, d);
    drop_ce();
    settle_none();
    model_ewen = 1'b0;
  endtask

  task automatic cmd_write(input logic [AB-1:0] a, input logic [DB-1:0] v, input int nbits);
    logic d;
    begin_cmd();
    send_hdr(2'b01, a, d);
    for (int i = DB - 1; i >= DB - nbits; i--) send_bit(v[i], d);
    drop_ce();
    if (nbits == DB && model_ewen) begin
      settle_prog(1'b1, PC, PC, "write");
      model_mem[a] = v;
    end else begin
      settle_prog(1'b0, 0, 0, "write");
    end
  endtask

  task automatic cmd_erase(input logic [AB-1:0] a);
    logic d;
    begin_cmd();
    send_hdr(2'b11, a, d);
    drop_ce();
    if (model_ewen) begin
      settle_prog(1'b1, PC, PC, "erase");
      model_mem[a] = '1;
    end else begin
      settle_prog(1'b0, 0, 0, "erase");
    end
  endtask

  task automatic cmd_eral();
    logic d;
    begin_cmd();
    send_hdr(2'b00, 6'h20, d);
    drop_ce();
    if (model_ewen) begin
      settle_prog(1'b1, PC, PC, "eral");
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '1;
    end else begin
      settle_prog(1'b0, 0, 0, "eral");
    end
  endtask

  task automatic cmd_wral(input logic [DB-1:0] v);
    logic d;
    begin_cmd();
    send_hdr(2'b00, 6'h10, d);
    for (int i = DB - 1; i >= 0; i--) send_bit(v[i], d);
    drop_ce();
    if (model_ewen) begin
      settle_prog(1'b1, PC, PC + DEPTH, "wral");
      for (int i = 0; i < DEPTH; i++) model_mem[i] = v;
    end else begin
      settle_prog(1'b0, 0, 0, "wral");
    end
  endtask

  task automatic cmd_read(input logic [AB-1:0] a, input int nwords);
    logic d;
    logic [DB-1:0] word;
    begin_cmd();
    send_hdr(2'b10, a, d);
    chk("read_dummy", {31'd0, d}, 32'd0);
    for (int w = 0; w < nwords; w++) begin
      word = '0;
      for (int b = 0; b < DB; b++) begin
        send_bit(1'($urandom_range(0, 1)), d);
        word = {word[DB-2:0], d};
      end
      chk("read_word", {16'd0, word}, {16'd0, model_mem[(int'(a) + w) % DEPTH]});
      if (w < 4) rd_buf[w] = word;
    end
    drop_ce();
    settle_none();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic d;
    bit done;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = '1;

    // Reset state
    wait_clk(4);
    chk("reset_do", {31'd0, eeprom_do}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    wait_clk(2);
    idle_exp = 1'b1;

    // No EWEN after reset: write is refused, power-up content reads back
    cmd_write(6'h05, 16'h1234, DB);
    cmd_read(6'h05, 1);
    chk("noewen_literal", {16'd0, rd_buf[0]}, 32'h0000FFFF);

    // EWEN then WRITE 0x05
    cmd_ewen();
    cmd_write(6'h05, 16'hA55A, DB);
    cmd_read(6'h05, 1);
    chk("write_literal", {16'd0, rd_buf[0]}, 32'h0000A55A);

    // Sequential read across the 0x3F -> 0x00 wrap
    cmd_write(6'h3F, 16'h0001, DB);
    cmd_write(6'h00, 16'h0002, DB);
    cmd_read(6'h3F, 2);
    chk("wrap_literal0", {16'd0, rd_buf[0]}, 32'h00000001);
    chk("wrap_literal1", {16'd0, rd_buf[1]}, 32'h00000002);

    // Aborted write, then a normal command decodes
    cmd_write(6'h07, 16'h5555, 8);
    cmd_read(6'h07, 1);
    chk("abort_literal", {16'd0, rd_buf[0]}, 32'h0000FFFF);
    cmd_write(6'h07, 16'h1357, DB);
    cmd_read(6'h07, 1);
    chk("after_abort_literal", {16'd0, rd_buf[0]}, 32'h00001357);

    // WRAL then ERASE 0x10, showing busy status while selected
    cmd_wral(16'hBEEF);
    begin_cmd();
    send_hdr(2'b11, 6'h10, d);
    drop_ce();
    busy_allowed = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (busy) done = 1'b1;
    end
    chk("erase_busy_rise", {31'd0, done}, 32'd1);
    ce = 1'b1;
    wait_clk(HALF);
    chk("busy_do_low", {31'd0, eeprom_do}, 32'd0);
    chk("busy_still_high", {31'd0, busy}, 32'd1);
    done = 1'b0;
    for (int i = 0; i < PC + 20 && !done; i++) begin
      @(negedge clock);
      if (!busy) done = 1'b1;
    end
    chk("erase_busy_fall", {31'd0, done}, 32'd1);
    wait_clk(HALF);
    chk("ready_do_high", {31'd0, eeprom_do}, 32'd1);
    ce = 1'b0;
    wait_clk(HALF);
    busy_allowed = 1'b0;
    idle_exp = 1'b1;
    model_mem[6'h10] = '1;
    cmd_read(6'h0F, 3);
    chk("wral_literal", {16'd0, rd_buf[0]}, 32'h0000BEEF);
    chk("erase_literal", {16'd0, rd_buf[1]}, 32'h0000FFFF);
    cmd_read(6'h3E, 4);

    // Reset in the middle of a program cycle
    begin_cmd();
    send_hdr(2'b01, 6'h02, d);
    for (int i = 0; i < DB; i++) send_bit(1'b0, d);
    drop_ce();
    busy_allowed = 1'b1;
    wait_clk(20);
    chk("prog_busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midprog_reset_do", {31'd0, eeprom_do}, 32'd1);
    chk("midprog_reset_busy", {31'd0, busy}, 32'd0);
    wait_clk(3);
    model_ewen = 1'b0;
    busy_allowed = 1'b0;
    reset = 1'b1;
    wait_clk(2);
    idle_exp = 1'b1;
    cmd_write(6'h02, 16'h1111, DB);
    cmd_read(6'h02, 1);
    chk("reset_keeps_literal", {16'd0, rd_buf[0]}, 32'h0000BEEF);

    // Randomised command mix against the model
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: cmd_ewen();
        1: cmd_ewds();
        2, 3: cmd_write(6'($urandom_range(0, DEPTH - 1)), 16'($urandom), DB);
        4: cmd_write(6'($urandom_range(0, DEPTH - 1)), 16'($urandom), $urandom_range(0, DB - 1));
        5: cmd_erase(6'($urandom_range(0, DEPTH - 1)));
        8: begin
          if ($urandom_range(0, 3) == 0) cmd_eral();
          else cmd_read(6'($urandom_range(0, DEPTH - 1)), 1);
        end
        9: begin
          if ($urandom_range(0, 3) == 0) cmd_wral(16'($urandom));
          else cmd_erase(6'($urandom_range(0, DEPTH - 1)));
        end
        default: cmd_read(6'($urandom_range(0, DEPTH - 1)), $urandom_range(1, 3));
      endcase
    end

    // Full array sweep, wrapping back to word 0
    cmd_read(6'h00, DEPTH + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
